or_truth_sweeper: RTL
=====================

Name: or_truth_sweeper

Overview:
- Sequencer wrapped around a small combinational gate under test, such as the 2-input OR gate.
- Upstream side: on `start`, drives every input combination onto `stim`.
- Downstream side: samples the gate output for each combination, builds the observed truth table and compares it against an expected table.
- Reports `done`, `pass` and a mismatch count. Intended as the self-checking stage for the gate-level exercises.

Parameters:
- N_IN, 2, number of gate inputs; stim width. Legal range 1..4.
- SETTLE, 1, clock cycles stim is held before gate_out is sampled. Must be >=1.
- EXPECTED, 4'b1110, expected truth table of width 2**N_IN. Bit i is the expected output for stim==i. The default is 2-input OR.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- gate_out  in  1  output of the gate under test
- stim  out  N_IN  input vector driven to the gate
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  1 when err_count==0 at sweep end; held until next accepted start
- tt  out  2**N_IN  observed truth table
- err_count  out  N_IN+1  number of mismatching entries

Behaviour:
- Clock/reset (already decided): one clock; reset is asynchronous and active-low.
- Reset: rst_n low immediately forces state=IDLE, stim=0, busy=0, done=0, pass=0, tt=0, err_count=0, idx=0, settle counter=0. This applies at any point, including mid-sweep; no done pulse is produced.
- FSM states are IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - stim=0, busy=0.
  - start=1 at a rising edge: go to APPLY; idx=0; clear tt, err_count and pass.
- APPLY:
  - stim=idx.
  - Settle counter counts SETTLE cycles, then go to SAMPLE.
- SAMPLE (one cycle; stim still = idx):
  - At the edge, tt[idx] <= gate_out.
  - If gate_out != EXPECTED[idx], err_count increments.
  - If idx == 2**N_IN-1, go to DONE. Otherwise idx increments, settle counter clears, go to APPLY.
- DONE (one cycle):
  - done=1, busy=1, stim=0.
  - pass=1 iff the final err_count==0.
  - Next state is IDLE.
- Latency:
  - Each vector occupies SETTLE+1 cycles.
  - done is high in the cycle starting 2**N_IN*(SETTLE+1) edges after the edge that accepted start. With defaults this is 8.
- start while busy (APPLY/SAMPLE/DONE) is ignored; no queuing.
- start held high continuously: a new sweep is accepted at the first IDLE edge. Sweeps are therefore back-to-back with exactly one IDLE cycle between them.
- tt, err_count and pass stay stable after DONE until the next accepted start.
- gate_out must be 0/1 at sampling; X is a bench error and not handled.
- err_count cannot overflow: width N_IN+1 covers 2**N_IN mismatches.
- Outputs are registered except stim, which decodes from state/idx (no glitch requirement).

Decomposition:
- Package or_sweep_pkg holds:
  - state encoding localparams (S_IDLE=2'd0, S_APPLY=2'd1, S_SAMPLE=2'd2, S_DONE=2'd3);
  - expected-table constants EXP_OR2=4'b1110, EXP_AND2=4'b1000, EXP_XOR2=4'b0110, EXP_NOR2=4'b0001.
- One sub-module is natural: sweep_index_counter. It holds the idx and settle counters, with inputs clr and step and outputs idx, settle_done and last.
- The FSM, compare logic and tt/err_count registers stay in or_truth_sweeper.

Test Plan:
1. Defaults, gate_out = stim[0]|stim[1]; start pulsed one cycle.
   -> stim sequence 0,0,1,1,2,2,3,3; done 8 edges after accept; tt=4'b1110, err_count=0, pass=1.
2. Defaults, gate_out tied 0.
   -> tt=4'b0000, err_count=3, pass=0, done still after 8 edges.
3. Defaults, AND gate attached.
   -> tt=4'b1000, err_count=2, pass=0. Repeat with EXPECTED=EXP_AND2 -> pass=1.
4. start held high for 30 cycles with the OR gate.
   -> sweeps accepted at cycles 0, 10 and 20; one IDLE cycle between DONE and the next APPLY; start pulses during busy have no effect.
5. rst_n low asynchronously mid-cycle while idx=2 in APPLY.
   -> all outputs 0 immediately (before the next edge); no done; a fresh start afterwards produces a normal sweep.
6. OR gate behind a 2-cycle delay.
   - SETTLE=1 -> pass=0.
   - SETTLE=3 -> pass=1, tt=4'b1110, done 16 edges after accept.

Source files
------------

// File: rtl/or_sweep_pkg.sv
// Shared state encoding and expected truth tables for the
// gate truth-table sweeper.
package or_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] EXP_OR2  = 4'b1110;
    localparam logic [3:0] EXP_AND2 = 4'b1000;
    localparam logic [3:0] EXP_XOR2 = 4'b0110;
    localparam logic [3:0] EXP_NOR2 = 4'b0001;

endpackage

// File: rtl/sweep_index_counter.sv
// Vector index and settle-time counters for the sweeper.
// clr zeroes both; step advances idx and restarts settling.
module sweep_index_counter #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_step,
    output logic [N_IN-1:0] o_idx,
    output logic            o_settle_done,
    output logic            o_last
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [N_IN-1:0] r_idx;
    logic [SW-1:0]   r_settle;
    logic            w_settle_done;

    assign w_settle_done = (r_settle == SW'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_settle <= '0;
        end else if (i_clr) begin
            r_idx    <= '0;
            r_settle <= '0;
        end else if (i_step) begin
            r_idx    <= r_idx + 1'b1;
            r_settle <= '0;
        end else if (!w_settle_done) begin
            // saturates so SAMPLE/DONE can sit on a held count
            r_settle <= r_settle + 1'b1;
        end
    end

    assign o_idx         = r_idx;
    assign o_settle_done = w_settle_done;
    assign o_last        = &r_idx;

endmodule

// File: rtl/or_truth_sweeper.sv
// Drives every input combination into a gate under test, records the
// observed truth table and counts mismatches against EXPECTED.
module or_truth_sweeper
    import or_sweep_pkg::*;
#(
    parameter int                     N_IN     = 2,
    parameter int                     SETTLE   = 1,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED = 4'b1110
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   gate_out,
    output logic [N_IN-1:0]        stim,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   tt,
    output logic [N_IN:0]          err_count
);

    state_t r_state;
    state_t w_next;

    logic [N_IN-1:0]       w_idx;
    logic                  w_settle_done;
    logic                  w_last;
    logic                  w_clr;
    logic                  w_step;
    logic [N_IN-1:0]       w_stim;
    logic                  w_miss;
    logic [N_IN:0]         w_err_nxt;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [(1<<N_IN)-1:0]  r_tt;
    logic [N_IN:0]         r_err;

    sweep_index_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_clr),
        .i_step        (w_step),
        .o_idx         (w_idx),
        .o_settle_done (w_settle_done),
        .o_last        (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_stim = '0;
        w_clr  = 1'b0;
        w_step = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_clr = 1'b1;
                if (start) w_next = S_APPLY;
            end
            S_APPLY: begin
                w_stim = w_idx;
                if (w_settle_done) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_stim = w_idx;
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_step = 1'b1;
                    w_next = S_APPLY;
                end
            end
            S_DONE: w_next = S_IDLE;
        endcase
    end

    assign w_miss    = (gate_out != EXPECTED[w_idx]);
    assign w_err_nxt = r_err + {{N_IN{1'b0}}, w_miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_tt   <= '0;
            r_err  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_pass <= 1'b0;
                        r_tt   <= '0;
                        r_err  <= '0;
                    end
                end
                S_APPLY: ;
                S_SAMPLE: begin
                    r_tt[w_idx] <= gate_out;
                    r_err       <= w_err_nxt;
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_pass <= (w_err_nxt == '0);
                    end
                end
                S_DONE: r_busy <= 1'b0;
            endcase
        end
    end

    assign stim      = w_stim;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign tt        = r_tt;
    assign err_count = r_err;

endmodule
